// File: rtl/rx_interface.sv
// ---------------------------------------------------------------------------
// rx_interface
// Command parser that sits between the UART receive FIFO and the ALU operand
// registers. It pops ASCII bytes from a first-word-fall-through FIFO and
// parses lines of the form "A,B,OP" ended by CR or LF, where each field is a
// decimal number.
//  - A well-formed line updates op_a/op_b/op_code and pulses cmd_valid.
//  - A malformed line is consumed up to its terminator, then err pulses.
//  - Blank lines are ignored without any pulse.
//  - Spaces are ignored anywhere, including between digits.
//
// Parameters
//   DBIT    width of op_a/op_b; the A and B field limit is 2**DBIT-1
//   OPW     width of op_code; the OP field limit is 2**OPW-1
//   MAXDIG  maximum decimal digits per field (leading zeros count)
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high reset
//   rx_empty   FIFO empty flag; r_data is valid when low
//   r_data     FIFO head byte
//   rd         FIFO pop strobe, one cycle per consumed byte
//   op_a       operand A of the last valid command
//   op_b       operand B of the last valid command
//   op_code    opcode of the last valid command
//   cmd_valid  one-cycle pulse: new command on op_a/op_b/op_code
//   err        one-cycle pulse: malformed line discarded
//
// FSM states
//   state  | meaning
//   IDLE   | wait for a byte; latch the FIFO head into byte_reg
//   FETCH  | pop the latched byte from the FIFO (rd high)
//   DECODE | classify byte_reg and update the parser registers
// ---------------------------------------------------------------------------
module rx_interface #(
    parameter int DBIT   = 8,
    parameter int OPW    = 6,
    parameter int MAXDIG = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [7:0]      r_data,
    output logic            rd,
    output logic [DBIT-1:0] op_a,
    output logic [DBIT-1:0] op_b,
    output logic [OPW-1:0]  op_code,
    output logic            cmd_valid,
    output logic            err
);

    // Accumulator carries four spare bits so one extra digit beyond the
    // field limit still fits and can be detected as an overflow.
    localparam int AW = DBIT + 4;
    localparam int XW = AW + 4;
    localparam int NW = $clog2(MAXDIG + 1);

    localparam logic [XW-1:0] DATA_LIM = XW'((1 << DBIT) - 1);
    localparam logic [XW-1:0] OP_LIM   = XW'((1 << OPW) - 1);
    localparam logic [NW-1:0] MAX_NDIG = NW'(MAXDIG);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE
    } state_t;

    state_t            state;
    logic [7:0]        byte_reg;
    logic [AW-1:0]     acc;
    logic [NW-1:0]     ndig;
    logic [1:0]        fidx;
    logic              errf;
    logic [DBIT-1:0]   field0;
    logic [DBIT-1:0]   field1;

    // Byte classification and next accumulator value.
    logic              is_digit;
    logic              is_term;
    logic [XW-1:0]     acc_next;
    logic [XW-1:0]     field_lim;

    assign is_digit  = (byte_reg >= CH_ZERO) && (byte_reg <= CH_NINE);
    assign is_term   = (byte_reg == CH_CR) || (byte_reg == CH_LF);
    assign acc_next  = ({4'b0000, acc} * XW'(10)) + {{AW{1'b0}}, byte_reg[3:0]};
    assign field_lim = (fidx == 2'd2) ? OP_LIM : DATA_LIM;

    // Pop strobe is a pure state decode: the byte was latched in IDLE while
    // the FIFO was non-empty, and nothing else pops, so it is still present.
    assign rd = (state == FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            byte_reg  <= 8'h00;
            acc       <= '0;
            ndig      <= '0;
            fidx      <= 2'd0;
            errf      <= 1'b0;
            field0    <= '0;
            field1    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_code   <= '0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        byte_reg <= r_data;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    state <= DECODE;
                end

                DECODE: begin
                    state <= IDLE;
                    if (is_term) begin
                        if (!errf && (fidx == 2'd0) && (ndig == '0)) begin
                            // blank line: nothing to report
                        end else if (!errf && (fidx == 2'd2) && (ndig != '0)) begin
                            op_a      <= field0;
                            op_b      <= field1;
                            op_code   <= acc[OPW-1:0];
                            cmd_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        acc  <= '0;
                        ndig <= '0;
                        fidx <= 2'd0;
                        errf <= 1'b0;
                    end else if (errf) begin
                        // discarding the rest of a bad line
                    end else if (byte_reg == CH_SPACE) begin
                        // spaces never affect parsing
                    end else if (is_digit) begin
                        if ((ndig == MAX_NDIG) || (acc_next > field_lim)) begin
                            errf <= 1'b1;
                        end else begin
                            acc  <= acc_next[AW-1:0];
                            ndig <= ndig + NW'(1);
                        end
                    end else if (byte_reg == CH_COMMA) begin
                        if ((ndig == '0) || (fidx == 2'd2)) begin
                            errf <= 1'b1;
                        end else begin
                            if (fidx == 2'd0) begin
                                field0 <= acc[DBIT-1:0];
                            end else begin
                                field1 <= acc[DBIT-1:0];
                            end
                            fidx <= fidx + 2'd1;
                            acc  <= '0;
                            ndig <= '0;
                        end
                    end else begin
                        errf <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
